// File: rtl/dsp_logic_simd.sv
// SIMD bitwise-logic unit modelled on a DSP48E2 in logic-unit mode: AND/OR/XOR/XNOR
// over 1, 2 or 4 lanes packed into the 48-bit ALU, two register stages, valid/ready.
module dsp_logic_simd #(
  parameter int LANES = 2,
  parameter int WIDTH = 24
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             op,
  input  logic [LANES*WIDTH-1:0] a,
  input  logic [LANES*WIDTH-1:0] b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] y
);

  localparam int LW = 48 / LANES;

  // Lane count picks the DSP SIMD mode (ONE48/TWO24/FOUR12); width must fit its slot.
  if (!(LANES == 1 || LANES == 2 || LANES == 4) || WIDTH < 1 || WIDTH > LW) begin : g_param_err
    $error("dsp_logic_simd: illegal LANES=%0d / WIDTH=%0d", LANES, WIDTH);
  end

  logic [47:0] a_word;
  logic [47:0] b_word;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_pack
    assign a_word[gi*LW +: WIDTH] = a[gi*WIDTH +: WIDTH];
    assign b_word[gi*LW +: WIDTH] = b[gi*WIDTH +: WIDTH];
    if (LW > WIDTH) begin : g_pad
      assign a_word[gi*LW+WIDTH +: LW-WIDTH] = '0;
      assign b_word[gi*LW+WIDTH +: LW-WIDTH] = '0;
    end
  end

  logic [3:0]  alumode_dec;
  logic [8:0]  opmode_dec;

  always_comb begin
    alumode_dec = 4'b1100;
    opmode_dec  = 9'b000110011;
    case (op)
      2'b00: begin alumode_dec = 4'b1100; opmode_dec = 9'b000110011; end
      2'b01: begin alumode_dec = 4'b1100; opmode_dec = 9'b000111011; end
      2'b10: begin alumode_dec = 4'b0100; opmode_dec = 9'b000110011; end
      default: begin alumode_dec = 4'b0101; opmode_dec = 9'b000110011; end
    endcase
  end

  logic        ce1, ce2;
  logic        v1_q, v1_d, v2_q, v2_d;
  logic [29:0] a_q, a_d;
  logic [17:0] b_q, b_d;
  logic [47:0] c_q, c_d;
  logic [3:0]  alumode_q, alumode_d;
  logic [8:0]  opmode_q, opmode_d;
  logic [47:0] p_q, p_d;
  logic [47:0] alu_out;

  // Bubble-collapsing enables: a stage advances when empty or when downstream moves.
  assign ce2       = ~v2_q | out_ready;
  assign ce1       = ~v1_q | ce2;
  assign in_ready  = ce1;
  assign out_valid = v2_q;

  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    c_d       = c_q;
    alumode_d = alumode_q;
    opmode_d  = opmode_q;
    v1_d      = v1_q;
    if (ce1) begin
      a_d       = b_word[47:18];
      b_d       = b_word[17:0];
      c_d       = a_word;
      alumode_d = alumode_dec;
      opmode_d  = opmode_dec;
      v1_d      = in_valid;
    end
  end

  // Logic unit: X = A:B, Z = C, W must be zero; Y selects all-zeros or all-ones.
  logic [47:0] x_mux, z_mux;
  logic        y_ones;

  always_comb begin
    x_mux   = (opmode_q[1:0] == 2'b11) ? {a_q, b_q} : 48'd0;
    z_mux   = (opmode_q[6:4] == 3'b011) ? c_q : 48'd0;
    y_ones  = (opmode_q[3:2] == 2'b10);
    alu_out = '0;
    if (opmode_q[8:7] == 2'b00) begin
      case (alumode_q)
        4'b1100: alu_out = y_ones ? (x_mux | z_mux) : (x_mux & z_mux);
        4'b0100: alu_out = y_ones ? ~(x_mux ^ z_mux) : (x_mux ^ z_mux);
        4'b0101: alu_out = y_ones ? (x_mux ^ z_mux) : ~(x_mux ^ z_mux);
        default: alu_out = '0;
      endcase
    end
  end

  always_comb begin
    p_d  = p_q;
    v2_d = v2_q;
    if (ce2) begin
      p_d  = alu_out;
      v2_d = v1_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      alumode_q <= '0;
      opmode_q  <= '0;
      v1_q      <= 1'b0;
      p_q       <= '0;
      v2_q      <= 1'b0;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      c_q       <= c_d;
      alumode_q <= alumode_d;
      opmode_q  <= opmode_d;
      v1_q      <= v1_d;
      p_q       <= p_d;
      v2_q      <= v2_d;
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_unpack
    assign y[gi*WIDTH +: WIDTH] = p_q[gi*LW +: WIDTH];
  end

endmodule

// File: tb/tb_dsp_logic_simd.sv
// Directed + randomised checks of dsp_logic_simd against a queue-based bitwise model.
module tb_dsp_logic_simd;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  op;
  logic [47:0] a, b, y;

  logic        iv4, ir4, ov4;
  logic [1:0]  op4;
  logic [31:0] a4, b4, y4;

  logic        iv1, ir1, ov1;
  logic [1:0]  op1;
  logic [47:0] a1, b1, y1;

  dsp_logic_simd dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .y(y)
  );

  dsp_logic_simd #(.LANES(4), .WIDTH(8)) dut4 (
    .clock(clock), .reset(reset), .in_valid(iv4), .in_ready(ir4), .op(op4),
    .a(a4), .b(b4), .out_valid(ov4), .out_ready(1'b1), .y(y4)
  );

  dsp_logic_simd #(.LANES(1), .WIDTH(48)) dut1 (
    .clock(clock), .reset(reset), .in_valid(iv1), .in_ready(ir1), .op(op1),
    .a(a1), .b(b1), .out_valid(ov1), .out_ready(1'b1), .y(y1)
  );

  int checks = 0;
  int failures = 0;
  int pops = 0;
  logic [47:0] q[$];

  function automatic logic [47:0] ref_op(input logic [1:0] o, input logic [47:0] x, input logic [47:0] z,
                                         input logic [47:0] mask);
    logic [47:0] r;
    case (o)
      2'b00: r = x & z;
      2'b01: r = x | z;
      2'b10: r = x ^ z;
      default: r = ~(x ^ z);
    endcase
    return r & mask;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle of the main DUT: score handshakes seen before the edge, then advance.
  task automatic tick();
    logic [47:0] exp;
    #1;
    if (reset) begin
      q.delete();
    end else begin
      if (out_valid && out_ready) begin
        check("output_expected", {63'd0, q.size() > 0}, 64'd1);
        if (q.size() > 0) begin
          exp = q.pop_front();
          pops++;
          check("scoreboard_y", {16'd0, y}, {16'd0, exp});
          $display("out #%0d y=%h exp=%h", pops, y, exp);
        end
      end
      if (in_valid && in_ready) q.push_back(ref_op(op, a, b, '1));
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic randomize_inputs();
    op = 2'($urandom_range(0, 3));
    a  = {16'($urandom), $urandom};
    b  = {16'($urandom), $urandom};
  endtask

  logic [47:0] basic_exp [4];
  logic [47:0] y_hold;
  int          sent, pops_before;

  initial begin
    basic_exp[0] = 48'hF000F0_000F00;
    basic_exp[1] = 48'hFFF0FF_0FFF0F;
    basic_exp[2] = 48'h0FF00F_0FF00F;
    basic_exp[3] = 48'hF00FF0_F00FF0;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = 2'b00; a = '0; b = '0;
    iv4 = 1'b0; op4 = 2'b00; a4 = '0; b4 = '0;
    iv1 = 1'b0; op1 = 2'b00; a1 = '0; b1 = '0;
    @(negedge clock);
    in_valid = 1'b1;
    tick();
    tick();
    #1;
    check("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check("reset_y", {16'd0, y}, 64'd0);
    check("reset_in_ready", {63'd0, in_ready}, 64'd1);
    reset = 1'b0;
    in_valid = 1'b0;
    tick();
    check("reset_drop", {63'd0, out_valid}, 64'd0);

    // Basic ops with fixed operands and exact 2-cycle latency.
    for (int k = 0; k < 4; k++) begin
      op = 2'(k); a = 48'hF0F0F0_0F0F0F; b = 48'hFF00FF_00FF00; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      #1 check("lat_cycle1_idle", {63'd0, out_valid}, 64'd0);
      tick();
      #1 check("lat_cycle2_valid", {63'd0, out_valid}, 64'd1);
      check("basic_op_y", {16'd0, y}, {16'd0, basic_exp[k]});
      tick();
    end

    // Narrow lanes: 4 x 8.
    iv4 = 1'b1; op4 = 2'b10; a4 = 32'hFFAA5500; b4 = 32'h0F0F0F0F;
    @(negedge clock); iv4 = 1'b0;
    @(negedge clock); #1;
    check("narrow_valid", {63'd0, ov4}, 64'd1);
    check("narrow_xor", {32'd0, y4}, 64'h00000000F0A55A0F);
    check("narrow_xor_model", {32'd0, y4}, {16'd0, ref_op(2'b10, 48'hFFAA5500, 48'h0F0F0F0F, 48'hFFFFFFFF)});
    iv4 = 1'b1; op4 = 2'b11; a4 = 32'hFFFFFFFF; b4 = 32'hFFFFFFFF;
    @(negedge clock); iv4 = 1'b0;
    @(negedge clock); #1;
    check("narrow_xnor_ones", {32'd0, y4}, 64'h00000000FFFFFFFF);
    iv4 = 1'b1; op4 = 2'b01; a4 = 32'h80018001; b4 = 32'h01800180;
    @(negedge clock); iv4 = 1'b0;
    @(negedge clock); #1;
    check("narrow_lane_isolation", {32'd0, y4}, 64'h0000000081818181);

    // Single 48-bit lane.
    iv1 = 1'b1; op1 = 2'b00; a1 = 48'h800000000001; b1 = 48'hFFFFFFFFFFFF;
    @(negedge clock); iv1 = 1'b0;
    @(negedge clock); #1;
    check("single_lane_valid", {63'd0, ov1}, 64'd1);
    check("single_lane_and", {16'd0, y1}, 64'h0000800000000001);

    // Backpressure: output stalled for cycles 0..5 while streaming 4 transactions.
    sent = 0;
    pops_before = pops;
    y_hold = '0;
    for (int cyc = 0; cyc < 40 && (sent < 4 || q.size() > 0); cyc++) begin
      out_ready = (cyc >= 6);
      in_valid  = (sent < 4);
      randomize_inputs();
      #1;
      if (cyc >= 2 && cyc < 6) begin
        check("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
        check("bp_out_valid", {63'd0, out_valid}, 64'd1);
        if (cyc == 2) y_hold = y;
        else check("bp_y_stable", {16'd0, y}, {16'd0, y_hold});
      end
      if (cyc == 6) check("bp_drain_and_accept", {63'd0, in_ready}, 64'd1);
      if (in_valid && in_ready) sent++;
      tick();
    end
    check("bp_all_sent", 64'(sent), 64'd4);
    check("bp_all_drained", 64'(pops - pops_before), 64'd4);
    in_valid = 1'b0;
    out_ready = 1'b1;

    // Reset mid-stream with both stages full and output stalled.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      randomize_inputs();
      tick();
    end
    #1 check("pre_reset_stalled", {62'd0, out_valid, in_ready}, 64'd2);
    reset = 1'b1;
    in_valid = 1'b1;
    tick();
    reset = 1'b0;
    in_valid = 1'b0;
    #1;
    check("midreset_out_valid", {63'd0, out_valid}, 64'd0);
    check("midreset_y", {16'd0, y}, 64'd0);
    check("midreset_in_ready", {63'd0, in_ready}, 64'd1);
    out_ready = 1'b1;
    pops_before = pops;
    in_valid = 1'b1; op = 2'b01; a = 48'h123456_789ABC; b = 48'h0F0F0F_F0F0F0;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check("midreset_first_result", 64'(pops - pops_before), 64'd1);

    // Randomised soak.
    for (int cyc = 0; cyc < 10000; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      randomize_inputs();
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 10 && q.size() > 0; k++) tick();
    check("soak_drained", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
